regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Write-port controller for the 16-entry general-purpose register file. It arbitrates between the control unit's single-cycle register writes and the debug/loader port's multi-register burst writes. It sequences burst addresses with wrap-around and drives the register file's one-hot write enables and write data from registers. It sits between the control unit, the debug loader and the register file, and replaces direct write-enable decoding for the write path.

## Interface
Parameters:
- DATA_W, 32, register data width
- STARVE_LIMIT, 4, consecutive CPU wins during a burst before one pending debug beat is forced through

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  asynchronous, active-high reset
- cpu_req  in  1  control unit requests a write this cycle
- cpu_reg  in  4  target register index, 0..15
- cpu_data  in  DATA_W  write data
- cpu_gnt  out  1  combinational; write accepted at this edge
- dbg_req  in  1  burst request; sampled only in IDLE
- dbg_start  in  4  first register of the burst
- dbg_count  in  4  number of registers minus one (0 means 1 register, 15 means 16 registers)
- dbg_valid  in  1  a debug data beat is present
- dbg_data  in  DATA_W  beat data
- dbg_ready  out  1  combinational; beat accepted at this edge
- dbg_busy  out  1  registered; high while in BURST
- dbg_done  out  1  registered; one-cycle pulse, high in the cycle the last burst write is driven
- rf_we  out  16  registered one-hot write enable; bit 15 is R0 and bit 0 is R15 (register n maps to 16'h8000 >> n)
- rf_wdata  out  DATA_W  registered write data

## Operation
- FSM states are IDLE and BURST.
- Reset state: IDLE. rf_we=16'h0000, rf_wdata=0, dbg_busy=0, dbg_done=0, burst pointer/remaining=0, streak=0.
- IDLE:
  - cpu_gnt = cpu_req. dbg_ready = 0.
  - When dbg_req=1: latch ptr=dbg_start and rem=dbg_count, then go to BURST.
  - A cpu_req in the same cycle is still granted.
- BURST arbitration, each cycle:
  - If cpu_req=1 and (streak < STARVE_LIMIT or dbg_valid=0): CPU wins. cpu_gnt=1, dbg_ready=0. streak increments only when dbg_valid=1, saturating at STARVE_LIMIT.
  - Otherwise, if dbg_valid=1: debug wins. dbg_ready=1, cpu_gnt=0, streak=0. The beat is written to register ptr, then ptr = ptr+1 mod 16.
  - If rem==0 at acceptance, this is the last beat: go to IDLE and set dbg_done=1 on the next cycle. Otherwise rem decrements.
  - If neither wins, nothing is accepted and the state holds.
- dbg_req is ignored while in BURST. dbg_start and dbg_count are ignored except at latch time.
- Write path: whichever requester is accepted at edge k sets rf_we to the one-hot code of its register and rf_wdata to its data, both valid from edge k until edge k+1. If nothing is accepted, rf_we=0 and rf_wdata holds its previous value.
- rf_we has at most one bit set in any cycle. The CPU and debug requesters are never both accepted in the same cycle.
- streak resets to 0 on entering BURST.

## Timing
- Write latency: one cycle from acceptance to rf_we/rf_wdata, with each write lasting exactly one cycle. Back-to-back writes are allowed at one per cycle.
- Burst start: dbg_req is sampled at edge k, dbg_busy rises at k+1, and the first beat can be accepted at edge k+1.
- dbg_done goes high on the cycle after the last beat is accepted, coincident with the last rf_we. dbg_busy falls in that same cycle.
- Wrap-around: ptr goes from 15 to 0, so rf_we goes 16'h0001 then 16'h8000.
- clear asserted at any time, including mid-burst, immediately forces all outputs to their reset values. The burst is abandoned and no partial state survives. After release the block is in IDLE.
- Starvation bound: with continuous cpu_req and dbg_valid, debug gets at least 1 beat per STARVE_LIMIT+1 cycles.

## Test plan
- Reset: clear=1 with any inputs -> rf_we=0000, rf_wdata=0, dbg_busy=0, dbg_done=0, cpu_gnt=0 in BURST-independent IDLE with cpu_req=0.
- CPU write: cpu_req=1, cpu_reg=5, cpu_data=32'hDEADBEEF for 1 cycle -> cpu_gnt=1 in that cycle; the next cycle shows rf_we=16'h0400, rf_wdata=DEADBEEF; rf_we=0 the cycle after.
- Wrapping burst: dbg_start=14, dbg_count=3, dbg_valid held high, data A,B,C,D -> rf_we sequence 0002, 0001, 8000, 4000 with data A–D on consecutive cycles; dbg_done high with 4000; dbg_busy low in that same cycle.
- Contention: in BURST with cpu_req and dbg_valid held high for 10 cycles -> grants follow CPU×4, DBG×1, CPU×4, DBG×1; rf_we is always one-hot.
- Simultaneous: cpu_req=1 (R3) and dbg_req=1 in IDLE at the same edge -> CPU write to R3 (1000) and dbg_busy high next cycle; the first burst beat follows with no lost cycle.
- Reset mid-burst: clear pulsed after 2 of 8 beats -> rf_we=0 and dbg_busy=0 immediately; a new dbg_req with dbg_start=0 and dbg_count=0 then writes only R0 (8000) with dbg_done.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Write-side bus of the register-file write arbiter: control-unit port,
// debug burst port and the registered register-file write outputs.
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic [3:0]        cpu_reg;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_gnt;
  logic              dbg_req;
  logic [3:0]        dbg_start;
  logic [3:0]        dbg_count;
  logic              dbg_valid;
  logic [DATA_W-1:0] dbg_data;
  logic              dbg_ready;
  logic              dbg_busy;
  logic              dbg_done;
  logic [15:0]       rf_we;
  logic [DATA_W-1:0] rf_wdata;

  modport master (
    output cpu_req, cpu_reg, cpu_data, dbg_req, dbg_start, dbg_count, dbg_valid, dbg_data,
    input  cpu_gnt, dbg_ready, dbg_busy, dbg_done, rf_we, rf_wdata
  );

  modport slave (
    input  cpu_req, cpu_reg, cpu_data, dbg_req, dbg_start, dbg_count, dbg_valid, dbg_data,
    output cpu_gnt, dbg_ready, dbg_busy, dbg_done, rf_we, rf_wdata
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Arbitrates single-cycle CPU writes against debug burst writes and drives
// the register file's one-hot write enable (R0 = bit 15) and write data.
module regfile_write_arbiter #(
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic                  clock,
  input logic                  clear,
  regfile_write_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t            r_state;
  logic [3:0]        r_ptr;
  logic [3:0]        r_rem;
  logic [SW-1:0]     r_streak;
  logic [15:0]       r_we;
  logic [DATA_W-1:0] r_wdata;
  logic              r_busy;
  logic              r_done;

  logic              w_in_burst;
  logic              w_streak_ok;
  logic              w_cpu_win;
  logic              w_dbg_win;

  assign w_in_burst  = (r_state == S_BURST);
  assign w_streak_ok = (r_streak < SW'(STARVE_LIMIT));
  // In IDLE the CPU always wins; in BURST it yields once the streak limit is hit.
  assign w_cpu_win   = bus.cpu_req && (!w_in_burst || w_streak_ok || !bus.dbg_valid);
  assign w_dbg_win   = w_in_burst && !w_cpu_win && bus.dbg_valid;

  assign bus.cpu_gnt   = w_cpu_win;
  assign bus.dbg_ready = w_dbg_win;
  assign bus.dbg_busy  = r_busy;
  assign bus.dbg_done  = r_done;
  assign bus.rf_we     = r_we;
  assign bus.rf_wdata  = r_wdata;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_rem    <= '0;
      r_streak <= '0;
      r_we     <= '0;
      r_wdata  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_we   <= '0;
      r_done <= 1'b0;

      if (w_cpu_win) begin
        r_we    <= 16'h8000 >> bus.cpu_reg;
        r_wdata <= bus.cpu_data;
      end else if (w_dbg_win) begin
        r_we    <= 16'h8000 >> r_ptr;
        r_wdata <= bus.dbg_data;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.dbg_req) begin
            r_ptr    <= bus.dbg_start;
            r_rem    <= bus.dbg_count;
            r_streak <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_BURST;
          end
        end
        S_BURST: begin
          if (w_cpu_win && bus.dbg_valid && w_streak_ok) begin
            r_streak <= r_streak + SW'(1);
          end
          if (w_dbg_win) begin
            r_streak <= '0;
            r_ptr    <= r_ptr + 4'd1;
            if (r_rem == 4'd0) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_rem <= r_rem - 4'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: directed scenarios followed by
// randomized traffic, checked against a queue-based burst model.
module tb_regfile_write_arbiter;
  localparam int DATA_W = 32;
  localparam int STARVE = 4;

  typedef struct {
    logic [15:0]       we;
    logic [DATA_W-1:0] data;
    logic              done;
  } exp_t;

  logic clock;
  logic clear;

  regfile_write_arbiter_if #(.DATA_W(DATA_W)) bus ();

  regfile_write_arbiter #(.DATA_W(DATA_W), .STARVE_LIMIT(STARVE)) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int errors = 0;

  exp_t              sb_q[$];
  int                burst_q[$];
  int                wins;
  logic [DATA_W-1:0] last_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a burst is the list of register indices still to be written.
  task automatic model_step();
    bit busy;
    bit owed;
    bit ecpu;
    bit edbg;
    exp_t e;
    busy = (burst_q.size() != 0);
    owed = busy && bus.dbg_valid && (wins >= STARVE);
    ecpu = bus.cpu_req && !owed;
    edbg = busy && bus.dbg_valid && !ecpu;
    chk("cpu_gnt", 64'(bus.cpu_gnt), 64'(ecpu));
    chk("dbg_ready", 64'(bus.dbg_ready), 64'(edbg));
    chk("dbg_busy", 64'(bus.dbg_busy), 64'(busy));
    if (ecpu) begin
      e.we   = 16'(1) << (15 - int'(bus.cpu_reg));
      e.data = bus.cpu_data;
      e.done = 1'b0;
      sb_q.push_back(e);
      if (busy && bus.dbg_valid) wins++;
    end
    if (edbg) begin
      int r;
      r = burst_q.pop_front();
      e.we   = 16'(1) << (15 - r);
      e.data = bus.dbg_data;
      e.done = (burst_q.size() == 0);
      sb_q.push_back(e);
      wins = 0;
    end
    if (!busy && bus.dbg_req) begin
      for (int i = 0; i <= int'(bus.dbg_count); i++) burst_q.push_back((int'(bus.dbg_start) + i) % 16);
      wins = 0;
    end
  endtask

  task automatic cycle(input logic cr, input logic [3:0] creg, input logic [DATA_W-1:0] cd,
                       input logic dr, input logic [3:0] ds, input logic [3:0] dc,
                       input logic dv, input logic [DATA_W-1:0] dd);
    bus.cpu_req   = cr;
    bus.cpu_reg   = creg;
    bus.cpu_data  = cd;
    bus.dbg_req   = dr;
    bus.dbg_start = ds;
    bus.dbg_count = dc;
    bus.dbg_valid = dv;
    bus.dbg_data  = dd;
    @(negedge clock);
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    #1;
    chk("rst_rf_we", 64'(bus.rf_we), 64'(0));
    chk("rst_rf_wdata", 64'(bus.rf_wdata), 64'(0));
    chk("rst_dbg_busy", 64'(bus.dbg_busy), 64'(0));
    chk("rst_dbg_done", 64'(bus.dbg_done), 64'(0));
    sb_q.delete();
    burst_q.delete();
    wins = 0;
    last_data = '0;
    bus.cpu_req   = 1'b0;
    bus.dbg_req   = 1'b0;
    bus.dbg_valid = 1'b0;
    @(negedge clock);
    chk("rst_cpu_gnt", 64'(bus.cpu_gnt), 64'(0));
    chk("rst_dbg_ready", 64'(bus.dbg_ready), 64'(0));
    @(posedge clock);
    #1;
    clear = 1'b0;
  endtask

  // Monitor: every write the DUT presents must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!clear) begin
        if (bus.rf_we != 16'h0000) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_write", 64'(bus.rf_we), 64'(0));
          end else begin
            e = sb_q.pop_front();
            chk("rf_we", 64'(bus.rf_we), 64'(e.we));
            chk("rf_wdata", 64'(bus.rf_wdata), 64'(e.data));
            chk("dbg_done", 64'(bus.dbg_done), 64'(e.done));
            last_data = e.data;
            $display("write we=%04h data=%08h done=%0b", bus.rf_we, bus.rf_wdata, bus.dbg_done);
          end
        end else begin
          chk("rf_wdata_hold", 64'(bus.rf_wdata), 64'(last_data));
          chk("done_no_write", 64'(bus.dbg_done), 64'(0));
        end
      end
    end
  end

  initial begin
    wins = 0;
    last_data = '0;
    clear = 1'b1;
    bus.cpu_req   = 1'b1;
    bus.cpu_reg   = 4'(($urandom));
    bus.cpu_data  = $urandom;
    bus.dbg_req   = 1'b1;
    bus.dbg_start = 4'(($urandom));
    bus.dbg_count = 4'(($urandom));
    bus.dbg_valid = 1'b1;
    bus.dbg_data  = $urandom;
    repeat (2) @(posedge clock);
    #1;
    do_clear();

    // Single CPU write to R5.
    cycle(1, 4'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);

    // Wrapping burst 14,15,0,1.
    cycle(0, 0, 0, 1, 4'd14, 4'd3, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'hAAAA0001);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'hBBBB0002);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'hCCCC0003);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'hDDDD0004);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);

    // Contention: CPU and debug both asserted for 10 cycles.
    cycle(0, 0, 0, 1, 4'd0, 4'd15, 0, 0);
    for (int i = 0; i < 10; i++) cycle(1, 4'($urandom), $urandom, 0, 0, 0, 1, $urandom);
    for (int i = 0; i < 20 && burst_q.size() != 0; i++) cycle(0, 0, 0, 0, 0, 0, 1, $urandom);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);

    // CPU write to R3 in the same cycle the burst is requested.
    cycle(1, 4'd3, 32'h33333333, 1, 4'd7, 4'd1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'h70707070);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'h80808080);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);

    // Clear after 2 of 8 beats, then a single-register burst to R0.
    cycle(0, 0, 0, 1, 4'd0, 4'd7, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'h11110000);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'h11110001);
    do_clear();
    cycle(0, 0, 0, 1, 4'd0, 4'd0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'h0F0F0F0F);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'h12345678);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_clear();
      end else begin
        cycle($urandom_range(0, 1) == 1, 4'($urandom), $urandom,
              $urandom_range(0, 4) == 0, 4'($urandom), 4'($urandom),
              $urandom_range(0, 9) < 6, $urandom);
      end
    end

    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    chk("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
